// File: rtl/fan_line_encoder.sv
// fan_line_encoder
// Packs a serial stream of (data, row) elements into NUM_OUT-lane beats of
// {ctrl, row, data} lines for the FAN adder tree. Each line's ctrl field is
// {valid, reserved, last_of_run, first_of_run}; unused lanes are all-zero.
//
// Ports:
//   clk        clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   in_valid   input element valid
//   in_ready   encoder accepts the element this cycle
//   in_data    element value
//   in_row     element row index
//   in_last    element ends the stream
//   out_valid  beat on out is valid
//   out_ready  downstream accepts the beat
//   out        beat, lane i at [i*DW_LINE +: DW_LINE]
module fan_line_encoder #(
    parameter int DW_DATA = 8,
    parameter int DW_ROW  = 4,
    parameter int DW_CTRL = 4,
    parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL,
    parameter int NUM_OUT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW_DATA-1:0]         in_data,
    input  logic [DW_ROW-1:0]          in_row,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_OUT*DW_LINE-1:0] out
);

    localparam int PW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                     state;
    logic [DW_DATA-1:0]         h_data;
    logic [DW_ROW-1:0]          h_row;
    logic                       h_first;
    logic [PW-1:0]              ptr;
    logic [NUM_OUT*DW_LINE-1:0] beat;
    logic [NUM_OUT*DW_LINE-1:0] beat_next;
    logic                       beat_valid;
    // Low during reset and until the first edge after release, so in_ready
    // never rises while reset is asserted.
    logic                       live;

    logic out_free;
    logic accept;
    logic row_change;
    logic commit;
    logic commit_last;
    logic close;
    logic drain;

    function automatic logic [DW_LINE-1:0] make_line(
        input logic [DW_ROW-1:0]  row,
        input logic [DW_DATA-1:0] data,
        input logic               first,
        input logic               last
    );
        logic [DW_CTRL-1:0] ctrl;
        ctrl              = '0;
        ctrl[DW_CTRL-1]   = 1'b1;
        ctrl[1]           = last;
        ctrl[0]           = first;
        return {ctrl, row, data};
    endfunction

    assign out_free    = !beat_valid || out_ready;
    assign in_ready    = live && (state != FLUSH) && out_free;
    assign accept      = in_valid && in_ready;
    assign row_change  = (in_row != h_row);
    // The held element is committed when its successor arrives, or when it
    // is the stream's final element and the output beat is free.
    assign commit      = ((state == HOLD) && accept) || ((state == FLUSH) && out_free);
    assign commit_last = (state == FLUSH) || row_change;
    assign close       = commit && ((ptr == PTR_LAST) || (state == FLUSH));
    assign drain       = beat_valid && out_ready;

    // While a beat is valid ptr is always 0, so a commit landing together
    // with a drain goes into lane 0 of a freshly cleared beat.
    always_comb begin
        beat_next = drain ? '0 : beat;
        if (commit) begin
            beat_next[ptr*DW_LINE +: DW_LINE] = make_line(h_row, h_data, h_first, commit_last);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            h_data     <= '0;
            h_row      <= '0;
            h_first    <= 1'b0;
            ptr        <= '0;
            beat       <= '0;
            beat_valid <= 1'b0;
            live       <= 1'b0;
        end else begin
            live <= 1'b1;
            beat <= beat_next;

            if (close) begin
                beat_valid <= 1'b1;
            end else if (drain) begin
                beat_valid <= 1'b0;
            end

            if (commit) begin
                ptr <= close ? '0 : ptr + 1'b1;
            end

            case (state)
                EMPTY: begin
                    if (accept) begin
                        h_data  <= in_data;
                        h_row   <= in_row;
                        h_first <= 1'b1;
                        state   <= in_last ? FLUSH : HOLD;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        h_data  <= in_data;
                        h_row   <= in_row;
                        h_first <= row_change;
                        state   <= in_last ? FLUSH : HOLD;
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_valid = beat_valid;
    assign out       = beat;

endmodule

// File: tb/tb_fan_line_encoder.sv
module tb_fan_line_encoder;

    localparam int DW_DATA = 8;
    localparam int DW_ROW  = 4;
    localparam int DW_CTRL = 4;
    localparam int DW_LINE = 16;
    localparam int NUM_OUT = 2;

    logic                       clk;
    logic                       rst_n;
    logic                       in_valid;
    logic                       in_ready;
    logic [DW_DATA-1:0]         in_data;
    logic [DW_ROW-1:0]          in_row;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_OUT*DW_LINE-1:0] out;

    fan_line_encoder #(
        .DW_DATA(DW_DATA), .DW_ROW(DW_ROW), .DW_CTRL(DW_CTRL),
        .DW_LINE(DW_LINE), .NUM_OUT(NUM_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_row(in_row), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW_DATA-1:0] d;
        logic [DW_ROW-1:0]  r;
    } elem_t;

    elem_t       cur[$];
    logic [31:0] expq[$];
    logic [31:0] obs[$];

    int   total = 0;
    int   bad   = 0;
    int   vcnt  = 0;
    int   rlow  = 0;
    bit   acc   = 0;
    bit   rnd   = 0;
    logic [31:0] s_out;
    logic        s_rdy;
    logic [31:0] held;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: once a stream is complete, derive every line from the
    // run rules and cut the list into NUM_OUT-lane beats, padding with zeros.
    task automatic finish_stream();
        logic [15:0] lines[$];
        int n;
        n = cur.size();
        for (int i = 0; i < n; i++) begin
            logic f, l;
            f = (i == 0) ? 1'b1 : (cur[i].r != cur[i-1].r);
            l = (i == n - 1) ? 1'b1 : (cur[i].r != cur[i+1].r);
            lines.push_back({1'b1, 1'b0, l, f, cur[i].r, cur[i].d});
        end
        for (int i = 0; i < n; i += NUM_OUT) begin
            logic [31:0] b;
            b = '0;
            for (int k = 0; k < NUM_OUT; k++)
                if (i + k < n) b[k*16 +: 16] = lines[i+k];
            expq.push_back(b);
        end
        cur.delete();
    endtask

    task automatic cycle();
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        s_out = out;
        s_rdy = in_ready;
        if (out_valid) vcnt++;
        if (!in_ready) rlow++;
        if (out_valid && out_ready) obs.push_back(out);
        acc = in_valid && in_ready;
        if (acc) begin
            elem_t e;
            e.d = in_data;
            e.r = in_row;
            cur.push_back(e);
            if (in_last) finish_stream();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] r, input logic l);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_row   = r;
        in_last  = l;
        t = 0;
        acc = 0;
        while (!acc && t < 50) begin
            cycle();
            t++;
        end
        if (!acc) chk("accept_timeout", 64'(t), 64'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int n;
        chk({tag, "_nbeats"}, 64'(obs.size()), 64'(expq.size()));
        n = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int i = 0; i < n; i++) chk({tag, "_beat"}, 64'(obs[i]), 64'(expq[i]));
        obs.delete();
        expq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_row    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        chk("ready_after_release", 64'(s_rdy), 64'd1);

        // Two-element run in one beat
        obs.delete(); expq.delete();
        vcnt = 0;
        send(8'h05, 4'd3, 1'b0);
        send(8'h07, 4'd3, 1'b1);
        idle(4);
        chk("run2_vcycles", 64'(vcnt), 64'd1);
        if (obs.size() > 0) chk("run2_beat", 64'(obs[0]), 64'hA307_9305);
        check_all("run2");

        // Mixed rows
        send(8'h11, 4'd1, 1'b0);
        send(8'h22, 4'd2, 1'b0);
        send(8'h33, 4'd2, 1'b1);
        idle(4);
        if (obs.size() > 1) begin
            chk("mixed_beat0", 64'(obs[0]), 64'h9222_B111);
            chk("mixed_beat1", 64'(obs[1]), 64'h0000_A233);
        end
        check_all("mixed");

        // Single element: exactly one cycle of in_ready low
        rlow = 0;
        send(8'hFF, 4'd7, 1'b1);
        idle(4);
        chk("single_rdy_low", 64'(rlow), 64'd1);
        if (obs.size() > 0) chk("single_beat", 64'(obs[0]), 64'h0000_B7FF);
        check_all("single");

        // Backpressure with a full beat
        out_ready = 1'b0;
        send(8'hA1, 4'd1, 1'b0);
        send(8'hA2, 4'd1, 1'b0);
        send(8'hA3, 4'd1, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hB4;
        in_row   = 4'd2;
        in_last  = 1'b1;
        cycle();
        held = s_out;
        chk("bp_beat", 64'(held), 64'h81A2_91A1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_stable", 64'(s_out), 64'(held));
            chk("bp_in_ready", 64'(s_rdy), 64'd0);
        end
        out_ready = 1'b1;
        send(8'hB4, 4'd2, 1'b1);
        idle(4);
        if (obs.size() > 1) begin
            chk("bp_beat0", 64'(obs[0]), 64'h81A2_91A1);
            chk("bp_beat1", 64'(obs[1]), 64'hB2B4_A1A3);
        end
        check_all("bp");

        // Back-to-back single-element streams on the same row
        send(8'h41, 4'd4, 1'b1);
        send(8'h42, 4'd4, 1'b1);
        idle(4);
        if (obs.size() > 1) begin
            chk("b2b_beat0", 64'(obs[0]), 64'h0000_B441);
            chk("b2b_beat1", 64'(obs[1]), 64'h0000_B442);
        end
        check_all("b2b");

        // Reset mid-stream
        send(8'h51, 4'd5, 1'b0);
        send(8'h52, 4'd5, 1'b0);
        send(8'h53, 4'd6, 1'b0);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", 64'(out), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        obs.delete(); expq.delete(); cur.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        obs.delete();
        send(8'h01, 4'd2, 1'b1);
        idle(4);
        if (obs.size() > 0) chk("post_rst_beat", 64'(obs[0]), 64'h0000_B201);
        check_all("post_rst");

        // Random traffic with random backpressure
        rnd = 1;
        for (int i = 0; i < 300; i++) begin
            logic l;
            l = (i == 299) ? 1'b1 : ($urandom_range(0, 5) == 0);
            send(8'($urandom), 4'($urandom_range(0, 3)), l);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rnd = 0;
        out_ready = 1'b1;
        idle(6);
        check_all("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
